// File: rtl/cosim_check_ctrl_if.sv
// cosim_check_ctrl_if: retire, check-request and response signals between the DUT, the controller and the reference model
interface cosim_check_ctrl_if;
  logic        ret_valid;
  logic [63:0] ret_pc;
  logic [31:0] ret_insn;
  logic        ret_ready;
  logic        chk_valid;
  logic [63:0] chk_pc;
  logic        chk_ready;
  logic        rsp_valid;
  logic        rsp_miss;
  logic [63:0] rsp_pc;
  logic [31:0] rsp_insn;
  modport master (
    input  ret_valid, ret_pc, ret_insn, chk_ready, rsp_valid, rsp_miss, rsp_pc, rsp_insn,
    output ret_ready, chk_valid, chk_pc
  );
  modport slave (
    output ret_valid, ret_pc, ret_insn, chk_ready, rsp_valid, rsp_miss, rsp_pc, rsp_insn,
    input  ret_ready, chk_valid, chk_pc
  );
endinterface

// File: rtl/cosim_check_ctrl.sv
// cosim_check_ctrl: lockstep retire-vs-reference checker with retire FIFO, mismatch counting and halt on errors or timeout
module cosim_check_ctrl #(
  parameter logic [63:0] START_PC = 64'h8000_0000,
  parameter int DEPTH = 8,
  parameter int MAX_ERR = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  cosim_check_ctrl_if.master   bus,
  output logic                 mismatch,
  output logic [63:0]          mm_pc,
  output logic [63:0]          mm_exp_pc,
  output logic [15:0]          err_count,
  output logic                 halted,
  output logic                 timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {SYNC, ISSUE, WAIT, HALT} state_t;
  state_t state, state_n;
  logic [63:0] pc_mem [DEPTH];
  logic [31:0] insn_mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [TW-1:0] tcnt;
  logic empty, full, push, pop, fail, issue, fire, expire;
  logic [15:0] err_inc;
  logic [63:0] head_pc;
  logic [31:0] head_insn;
  assign head_pc = pc_mem[rp[AW-1:0]];
  assign head_insn = insn_mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  // HALT keeps accepting so a dead checker never stalls the DUT
  assign bus.ret_ready = state == HALT || !full;
  assign push = bus.ret_valid && bus.ret_ready &&
                (state == ISSUE || state == WAIT || (state == SYNC && bus.ret_pc == START_PC));
  always_ff @(posedge clk)
    if (rst) state <= SYNC;
    else state <= state_n;
  always_comb begin
    state_n = state;
    issue = 1'b0;
    fire = 1'b0;
    pop = 1'b0;
    fail = 1'b0;
    expire = 1'b0;
    err_inc = err_count == 16'hFFFF ? err_count : err_count + 16'd1;
    case (state)
      SYNC: state_n = push ? ISSUE : SYNC;
      ISSUE: begin
        fire = bus.chk_valid && bus.chk_ready;
        issue = !bus.chk_valid && !empty && enable;
        state_n = fire ? WAIT : ISSUE;
      end
      WAIT: begin
        pop = bus.rsp_valid;
        fail = pop && (bus.rsp_miss || bus.rsp_insn != head_insn);
        expire = !bus.rsp_valid && tcnt == TW'(TIMEOUT - 1);
        state_n = expire ? HALT :
                  !pop ? WAIT :
                  (fail && MAX_ERR != 0 && err_inc == 16'(MAX_ERR)) ? HALT : ISSUE;
      end
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wp[AW-1:0]] <= bus.ret_pc;
      insn_mem[wp[AW-1:0]] <= bus.ret_insn;
    end
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      tcnt <= '0;
      bus.chk_valid <= 1'b0;
      bus.chk_pc <= '0;
      mismatch <= 1'b0;
      mm_pc <= '0;
      mm_exp_pc <= '0;
      err_count <= '0;
      halted <= 1'b0;
      timeout <= 1'b0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
      bus.chk_valid <= issue ? 1'b1 : fire ? 1'b0 : bus.chk_valid;
      bus.chk_pc <= issue ? head_pc : bus.chk_pc;
      mismatch <= fail;
      mm_pc <= fail ? head_pc : mm_pc;
      mm_exp_pc <= fail ? bus.rsp_pc : mm_exp_pc;
      err_count <= fail ? err_inc : err_count;
      halted <= halted || state_n == HALT;
      timeout <= timeout || expire;
    end
endmodule

// File: tb/tb_cosim_check_ctrl.sv
// tb_cosim_check_ctrl: directed checks of sync, match stream, mismatch, error halt, timeout and backpressure
module tb_cosim_check_ctrl;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic mismatch, halted, timeout;
  logic [63:0] mm_pc, mm_exp_pc;
  logic [15:0] err_count;
  int passed = 0, total = 0, hs = 0, mmc = 0;
  cosim_check_ctrl_if bus();
  cosim_check_ctrl #(.DEPTH(8), .MAX_ERR(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus.master), .mismatch(mismatch),
    .mm_pc(mm_pc), .mm_exp_pc(mm_exp_pc), .err_count(err_count), .halted(halted), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst && bus.chk_valid && bus.chk_ready) hs++;
    if (mismatch) mmc++;
  end
  function automatic logic [31:0] ins(logic [63:0] pc);
    return pc[31:0] ^ 32'h00A5_0013;
  endfunction
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic idle();
    bus.ret_valid = 1'b0;
    bus.ret_pc = '0;
    bus.ret_insn = '0;
    bus.chk_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_miss = 1'b0;
    bus.rsp_pc = '0;
    bus.rsp_insn = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic push(input logic [63:0] pc);
    bus.ret_valid = 1'b1;
    bus.ret_pc = pc;
    bus.ret_insn = ins(pc);
    step();
    bus.ret_valid = 1'b0;
  endtask
  task automatic do_check(input logic [63:0] exp_pc, input logic [31:0] r_insn, input logic r_miss,
                          input logic [63:0] r_pc, input logic push_en, input logic [63:0] push_pc);
    for (int k = 0; k < 8 && bus.chk_valid !== 1'b1; k++) step();
    chk("chk_valid", 64'(bus.chk_valid), 64'd1);
    chk("chk_pc", bus.chk_pc, exp_pc);
    bus.chk_ready = 1'b1;
    step();
    bus.chk_ready = 1'b0;
    chk("chk_drop", 64'(bus.chk_valid), 64'd0);
    bus.rsp_valid = 1'b1;
    bus.rsp_miss = r_miss;
    bus.rsp_pc = r_pc;
    bus.rsp_insn = r_insn;
    if (push_en) begin
      bus.ret_valid = 1'b1;
      bus.ret_pc = push_pc;
      bus.ret_insn = ins(push_pc);
    end
    step();
    bus.rsp_valid = 1'b0;
    bus.rsp_miss = 1'b0;
    bus.ret_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int hs0, mm0;
    logic [63:0] p;
    do_reset();
    rst = 1'b1;
    chk("rst_chk_valid", 64'(bus.chk_valid), 64'd0);
    chk("rst_chk_pc", bus.chk_pc, 64'd0);
    chk("rst_mismatch", 64'(mismatch), 64'd0);
    chk("rst_mm_pc", mm_pc, 64'd0);
    chk("rst_mm_exp_pc", mm_exp_pc, 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_ret_ready", 64'(bus.ret_ready), 64'd1);
    rst = 1'b0;
    push(64'h1000);
    push(64'h1004);
    step();
    chk("no_early_issue", 64'(bus.chk_valid), 64'd0);
    push(64'h8000_0000);
    hs0 = hs;
    mm0 = mmc;
    for (int i = 0; i < 20; i++) begin
      p = 64'h8000_0000 + 64'(4 * i);
      do_check(p, ins(p), 1'b0, p, 1'b1, p + 64'd4);
    end
    chk("match_handshakes", 64'(hs - hs0), 64'd20);
    chk("match_no_mismatch", 64'(mmc - mm0), 64'd0);
    chk("match_err_count", 64'(err_count), 64'd0);
    do_reset();
    push(64'h8000_0000);
    do_check(64'h8000_0000, ins(64'h8000_0000), 1'b0, 64'h8000_0000, 1'b1, 64'h8000_0004);
    do_check(64'h8000_0004, ins(64'h8000_0004), 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0008);
    do_check(64'h8000_0008, ins(64'h8000_0008), 1'b1, 64'h8000_000C, 1'b0, 64'd0);
    chk("mm_pulse", 64'(mismatch), 64'd1);
    chk("mm_pc", mm_pc, 64'h8000_0008);
    chk("mm_exp_pc", mm_exp_pc, 64'h8000_000C);
    chk("mm_err_count", 64'(err_count), 64'd1);
    chk("mm_not_halted", 64'(halted), 64'd0);
    step();
    chk("mm_one_cycle", 64'(mismatch), 64'd0);
    push(64'h8000_000C);
    do_check(64'h8000_000C, ins(64'h8000_000C) ^ 32'd1, 1'b0, 64'h8000_000C, 1'b0, 64'd0);
    chk("halt_mismatch", 64'(mismatch), 64'd1);
    chk("halt_err_count", 64'(err_count), 64'd2);
    chk("halt_mm_pc", mm_pc, 64'h8000_000C);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_no_timeout", 64'(timeout), 64'd0);
    chk("halt_ret_ready", 64'(bus.ret_ready), 64'd1);
    push(64'h8000_0010);
    bus.rsp_valid = 1'b1;
    bus.rsp_miss = 1'b1;
    step();
    bus.rsp_valid = 1'b0;
    bus.rsp_miss = 1'b0;
    repeat (3) step();
    chk("halt_no_chk", 64'(bus.chk_valid), 64'd0);
    chk("halt_ignores_rsp", 64'(err_count), 64'd2);
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("halt_ready_after", 64'(bus.ret_ready), 64'd1);
    do_reset();
    chk("to_rst_halted", 64'(halted), 64'd0);
    push(64'h8000_0000);
    for (int k = 0; k < 8 && bus.chk_valid !== 1'b1; k++) step();
    chk("to_chk_valid", 64'(bus.chk_valid), 64'd1);
    bus.chk_ready = 1'b1;
    step();
    bus.chk_ready = 1'b0;
    repeat (15) step();
    chk("to_pre_halted", 64'(halted), 64'd0);
    step();
    chk("to_halted", 64'(halted), 64'd1);
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_err_count", 64'(err_count), 64'd0);
    do_reset();
    bus.rsp_valid = 1'b1;
    bus.rsp_miss = 1'b1;
    step();
    bus.rsp_valid = 1'b0;
    bus.rsp_miss = 1'b0;
    step();
    chk("sync_rsp_mismatch", 64'(mismatch), 64'd0);
    chk("sync_rsp_err", 64'(err_count), 64'd0);
    for (int i = 0; i < 8; i++) begin
      push(64'h8000_0000 + 64'(4 * i));
      if (i == 6) chk("bp_ready_7", 64'(bus.ret_ready), 64'd1);
    end
    chk("bp_full", 64'(bus.ret_ready), 64'd0);
    bus.ret_valid = 1'b1;
    bus.ret_pc = 64'h8000_0020;
    bus.ret_insn = ins(64'h8000_0020);
    step();
    step();
    bus.ret_valid = 1'b0;
    chk("bp_still_full", 64'(bus.ret_ready), 64'd0);
    chk("bp_chk_valid", 64'(bus.chk_valid), 64'd1);
    chk("bp_pc_stable", bus.chk_pc, 64'h8000_0000);
    enable = 1'b0;
    step();
    chk("bp_hold_no_enable", 64'(bus.chk_valid), 64'd1);
    chk("bp_hold_pc", bus.chk_pc, 64'h8000_0000);
    enable = 1'b1;
    do_check(64'h8000_0000, ins(64'h8000_0000), 1'b0, 64'h8000_0000, 1'b1, 64'h8000_0020);
    chk("bp_ready_after_pop", 64'(bus.ret_ready), 64'd1);
    do_check(64'h8000_0004, ins(64'h8000_0004), 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0020);
    chk("bp_push_pop_same", 64'(bus.ret_ready), 64'd1);
    push(64'h8000_0024);
    chk("bp_full_again", 64'(bus.ret_ready), 64'd0);
    for (int i = 2; i < 10; i++) begin
      p = 64'h8000_0000 + 64'(4 * i);
      do_check(p, ins(p), 1'b0, p, 1'b0, 64'd0);
    end
    chk("bp_err_count", 64'(err_count), 64'd0);
    chk("bp_not_halted", 64'(halted), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
